// File: rtl/ml_qpi_host_if.sv
// Byte-stream, read-back stream and QPI pin bundle for ml_qpi_host.
// slave = the host block itself; master = SoC glue plus accelerator side.
interface ml_qpi_host_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dir;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       qpi_csb;
  logic       qpi_clk;
  logic [3:0] io_oe;
  logic [3:0] io_do;
  logic [3:0] io_di;
  logic       qpi_rdy;
  logic       busy;

  modport slave (
    input  in_valid, in_data, in_dir, in_last, out_ready, io_di, qpi_rdy,
    output in_ready, out_valid, out_data, qpi_csb, qpi_clk, io_oe, io_do, busy
  );
  modport master (
    output in_valid, in_data, in_dir, in_last, out_ready, io_di, qpi_rdy,
    input  in_ready, out_valid, out_data, qpi_csb, qpi_clk, io_oe, io_do, busy
  );
endinterface

// File: rtl/ml_qpi_host.sv
// Host-side QPI master: byte stream in, 4-bit QPI transfers out, read bytes back.
// Optional ML_QPI_RDY_WAIT_EN: gate transaction start / read bytes on qpi_rdy.
module ml_qpi_host #(
  parameter int CLKDIV      = 2,
  parameter int TURN_CYCLES = 2,
  parameter int CSB_HIGH    = 4
) (
  input  logic clk,
  input  logic reset,
  ml_qpi_host_if.slave bus
);
  localparam logic [7:0]  DIV_LOAD  = 8'(CLKDIV - 1);
  localparam logic [15:0] TURN_LOAD = 16'((TURN_CYCLES > 0) ? 2*TURN_CYCLES - 1 : 0);
  localparam logic [15:0] END_LOAD  = 16'((CSB_HIGH > 1) ? CSB_HIGH - 1 : 0);
  localparam bit          HAS_TURN  = TURN_CYCLES > 0;

  typedef enum logic [2:0] {
    S_IDLE, S_LO0, S_HI0, S_LO1, S_HI1, S_GAP, S_TURN, S_END
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [15:0] cnt;
  logic [7:0]  data_r;
  logic        dir_r, last_r;
  logic        in_ready, accept, phase_done, go_turn;

  assign phase_done = div_cnt == 8'd0;
  assign accept     = bus.in_valid && in_ready;
  assign go_turn    = HAS_TURN && (state == S_GAP) && !dir_r && bus.in_dir;

  // output decode
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:  in_ready = !reset;
      S_GAP:   in_ready = !last_r && !(bus.out_valid && !bus.out_ready);
      default: in_ready = 1'b0;
    endcase
`ifdef ML_QPI_RDY_WAIT_EN
    if (state == S_IDLE && !bus.qpi_rdy) in_ready = 1'b0;
    if (state == S_GAP && bus.in_dir && !bus.qpi_rdy) in_ready = 1'b0;
`endif
  end

`ifndef ML_QPI_RDY_WAIT_EN
  logic unused_rdy;
  assign unused_rdy = bus.qpi_rdy;
`endif

  assign bus.in_ready = in_ready;
  assign bus.busy     = state != S_IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LO0;
      S_LO0:  if (phase_done) state_nxt = S_HI0;
      S_HI0:  if (phase_done) state_nxt = S_LO1;
      S_LO1:  if (phase_done) state_nxt = S_HI1;
      S_HI1:  if (phase_done) state_nxt = S_GAP;
      S_GAP: begin
        if (last_r) state_nxt = S_END;
        else if (accept) state_nxt = go_turn ? S_TURN : S_LO0;
      end
      S_TURN: if (phase_done && cnt == 16'd0) state_nxt = S_LO0;
      S_END:  if (cnt == 16'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      cnt           <= '0;
      data_r        <= '0;
      dir_r         <= 1'b0;
      last_r        <= 1'b0;
      bus.qpi_csb   <= 1'b1;
      bus.qpi_clk   <= 1'b0;
      bus.io_oe     <= '0;
      bus.io_do     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      state <= state_nxt;
      if (bus.out_ready) bus.out_valid <= 1'b0;
      case (state)
        S_IDLE, S_GAP: begin
          if (state == S_GAP && last_r) begin
            // oe drops on the same edge csb rises
            bus.qpi_csb <= 1'b1;
            bus.io_oe   <= '0;
            cnt         <= END_LOAD;
          end else if (accept) begin
            data_r      <= bus.in_data;
            dir_r       <= bus.in_dir;
            last_r      <= bus.in_last;
            div_cnt     <= DIV_LOAD;
            bus.qpi_csb <= 1'b0;
            if (go_turn) begin
              bus.io_oe <= '0;
              cnt       <= TURN_LOAD;
            end else if (bus.in_dir) begin
              bus.io_oe <= '0;
            end else begin
              bus.io_oe <= 4'hF;
              bus.io_do <= bus.in_data[7:4];
            end
          end
        end
        S_LO0, S_HI0, S_LO1, S_HI1, S_TURN: begin
          div_cnt <= phase_done ? DIV_LOAD : div_cnt - 8'd1;
          if (phase_done) begin
            // read nibbles are taken on the cycle that drives qpi_clk high
            if (state == S_LO0 || state == S_LO1) bus.qpi_clk <= 1'b1;
            else if (state == S_TURN) bus.qpi_clk <= ~bus.qpi_clk;
            else bus.qpi_clk <= 1'b0;
            if (state == S_LO0 && dir_r) data_r[7:4] <= bus.io_di;
            if (state == S_HI0 && !dir_r) bus.io_do <= data_r[3:0];
            if (state == S_LO1 && dir_r) data_r[3:0] <= bus.io_di;
            if (state == S_HI1 && dir_r) begin
              bus.out_data  <= data_r;
              bus.out_valid <= 1'b1;
            end
            if (state == S_TURN && cnt != 16'd0) cnt <= cnt - 16'd1;
          end
        end
        S_END: cnt <= cnt - 16'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ml_qpi_host.md
Name: ml_qpi_host

Overview:
- Host-side QPI master inside ctrlsoc; directly upstream of mlaccel_top.
- Produces the qpi_csb / qpi_clk / qpi_io[3:0] signalling that mlaccel_top consumes.
- Turns a byte stream (command, address, data) from the SoC bus glue into 4-bit QPI transfers.
- Returns read-back bytes on an output stream.

Parameters:
- CLKDIV, 2: qpi_clk half-period in clk cycles; legal range 1..255.
- TURN_CYCLES, 2: full dummy qpi_clk periods inserted on a write->read direction change.
- CSB_HIGH, 4: minimum clk cycles qpi_csb stays high between transactions.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  byte request valid.
- in_ready  out  1  byte request accepted when in_valid && in_ready.
- in_data  in  8  byte to send; ignored for reads.
- in_dir  in  1  0 = write byte to accel, 1 = read byte from accel.
- in_last  in  1  deassert csb after this byte.
- out_valid  out  1  read byte available.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  8  read byte.
- qpi_csb  out  1  chip select, active low.
- qpi_clk  out  1  QPI clock, idles low.
- io_oe  out  4  per-line output enable; all bits equal.
- io_do  out  4  nibble driven.
- io_di  in  4  nibble sampled.
- qpi_rdy  in  1  accelerator ready flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: qpi_csb=1, qpi_clk=0, io_oe=0, io_do=0, in_ready=0, out_valid=0, out_data=0, busy=0, state=IDLE.
- First cycle after reset: in_ready=1.
- Phases: each qpi_clk phase lasts exactly CLKDIV clk cycles, timed by div_cnt counting CLKDIV-1 down to 0.
- Nibble order: high nibble first.
  - io_do changes only while qpi_clk is low.
  - io_di is sampled on the clk cycle in which qpi_clk is driven 0->1 (value present before the rise).
- States:
  - IDLE: in_ready=1. On accept, latch data/dir/last; qpi_csb=0 next cycle. Write: io_oe=4'hF, io_do=data[7:4]. Read: io_oe=0. Go to LO0.
  - LO0 (qpi_clk=0, CLKDIV cycles) -> HI0 (rise; read captures data[7:4]).
  - HI0 -> LO1: io_do=data[3:0].
  - LO1 -> HI1 (read captures data[3:0]).
  - HI1 -> GAP: qpi_clk=0. A read byte loads out_data and sets out_valid in the same cycle.
  - GAP, last=1: go to END; qpi_csb=1 on entry.
  - GAP, last=0: in_ready=1 unless (out_valid && !out_ready). On accept with same dir, or read->write: go directly to LO0 with the new nibble. On accept with write->read: io_oe=0, go to TURN.
  - GAP with no request: qpi_csb stays 0 and qpi_clk stays 0 indefinitely.
  - TURN: TURN_CYCLES full qpi_clk periods (2*CLKDIV*TURN_CYCLES clk cycles), oe=0, no sampling; then LO0.
  - END: qpi_csb=1 for CSB_HIGH cycles, in_ready=0; then IDLE.
- out_valid: cleared when out_ready is high. A new read byte must never overwrite a pending one; the stall rule in GAP guarantees this.
- io_oe: deasserts to 0 at the same clk edge qpi_csb rises.
- Reset mid-transfer: next cycle all outputs return to their reset values; the partial byte is dropped.
- CLKDIV=1: qpi_clk toggles every clk cycle; one byte spans 4 clk cycles LO0..HI1, plus 1 GAP cycle.

Optional Feature:
- Macro ML_QPI_RDY_WAIT_EN.
- Defined: in IDLE with a pending request, in_ready=0 while qpi_rdy=0; the transaction starts only once qpi_rdy=1. Within a transaction, GAP holds (no accept) while qpi_rdy=0 before a read byte.
- Undefined: qpi_rdy is ignored and in_ready follows the rules above.

Test Plan:
- Write burst, CLKDIV=2: bytes 8'h21, 8'hA5 (last) -> csb low for exactly 2*(4*2)+1 cycles plus setup; io_do sequence 2,1,A,5 stable at each rise; csb high >= 4 cycles after.
- Write 8'h03, then read 1 byte last; model drives io_di=4'hC then 4'h7 -> 2 turnaround periods with io_oe=0, out_data=8'hC7, out_valid until out_ready.
- Back-to-back reads with out_ready=0 -> second byte stalls in GAP (in_ready=0, qpi_clk low); releasing out_ready delivers first byte, then second, with no data lost.
- Reset asserted during HI0 of a write -> next cycle qpi_csb=1, io_oe=0, qpi_clk=0, busy=0; a new transaction then completes normally.
- CLKDIV=1, 3-byte write -> qpi_clk toggles every cycle, 6 rising edges, correct nibbles.
- With ML_QPI_RDY_WAIT_EN, qpi_rdy=0 for 20 cycles with a request pending -> csb stays high, in_ready=0; transaction begins the cycle after qpi_rdy=1.
